// File: rtl/exec_stim_pkg.sv
// exec_stim_pkg: shared types and constants for the execute-stage stimulus
// sequencer (exec_stim_seq) and its LFSR (stim_lfsr32).
//   state_t        sequencer states
//   LFSR_MASK      Galois feedback taps of the 32-bit vector generator
//   ALU_*          bit positions inside the one-hot alu_op vector
//   OPI_*          op_idx codes taken from the LFSR
//   alu_decode()   op_idx -> one-hot alu_op (load/store give all zeros)
package exec_stim_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

   localparam int ALU_W   = 9;
   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_AND = 2;
   localparam int ALU_OR  = 3;
   localparam int ALU_XOR = 4;
   localparam int ALU_SLL = 5;
   localparam int ALU_SRL = 6;
   localparam int ALU_SRA = 7;
   localparam int ALU_SLT = 8;

   localparam logic [3:0] OPI_ADD   = 4'd0;
   localparam logic [3:0] OPI_SUB   = 4'd1;
   localparam logic [3:0] OPI_AND   = 4'd2;
   localparam logic [3:0] OPI_OR    = 4'd3;
   localparam logic [3:0] OPI_XOR   = 4'd4;
   localparam logic [3:0] OPI_SLL   = 4'd5;
   localparam logic [3:0] OPI_SRL   = 4'd6;
   localparam logic [3:0] OPI_SRA   = 4'd7;
   localparam logic [3:0] OPI_SLT   = 4'd8;
   localparam logic [3:0] OPI_LOAD  = 4'd9;
   localparam logic [3:0] OPI_STORE = 4'd10;

   localparam int DRAIN_CYCLES = 2;

   // Codes 11..15 are unused by the generator and fold onto add so every
   // non-io vector still carries exactly one alu op.
   function automatic logic [ALU_W-1:0] alu_decode(input logic [3:0] op_idx);
      logic [ALU_W-1:0] onehot;
      onehot = '0;
      case (op_idx)
         OPI_ADD:             onehot[ALU_ADD] = 1'b1;
         OPI_SUB:             onehot[ALU_SUB] = 1'b1;
         OPI_AND:             onehot[ALU_AND] = 1'b1;
         OPI_OR:              onehot[ALU_OR]  = 1'b1;
         OPI_XOR:             onehot[ALU_XOR] = 1'b1;
         OPI_SLL:             onehot[ALU_SLL] = 1'b1;
         OPI_SRL:             onehot[ALU_SRL] = 1'b1;
         OPI_SRA:             onehot[ALU_SRA] = 1'b1;
         OPI_SLT:             onehot[ALU_SLT] = 1'b1;
         OPI_LOAD, OPI_STORE: onehot = '0;
         default:             onehot[ALU_ADD] = 1'b1;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// stim_lfsr32: 32-bit right-shifting Galois LFSR (taps LFSR_MASK).
//   clk, rst_n  clock, async active-low reset (state <= SEED)
//   load        reload SEED (wins over advance)
//   advance     step the register once
//   state       current 32-bit value
module stim_lfsr32
   import exec_stim_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] state
);

   logic [31:0] state_next;

   assign state_next = {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'h0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (load) begin
         state <= SEED;
      end else if (advance) begin
         state <= state_next;
      end
   end

endmodule

// File: rtl/exec_stim_seq.sv
// exec_stim_seq: self-sequencing execute-stage stimulus source. A start pulse
// in IDLE issues NUM_VEC LFSR-derived vectors, keeps a two-deep shadow of
// issued results on ma_* / wb_*, drains two bubbles and pulses done.
//
// Optional build macro: COMPRESSED_EN adds output 'compressed' (LFSR bit 21)
// and makes pc advance by 2 for compressed vectors.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begins a run when IDLE (ignored otherwise)
//   stall_in                   hold everything this cycle
//   clear_in                   in RUN: next cycle is a bubble, vector kept
//   valid, done                vector qualifier, end-of-run pulse
//   pc, rd, rs1, rs2           vector pc and register indices
//   data1, data2, imm          operands and immediate
//   with_imm                   op2 selects imm
//   alu_op, load_op, store_op  one-hot op flags
//   compressed                 (COMPRESSED_EN only) 16-bit encoding flag
//   ma_rd/ma_data, wb_rd/wb_data  forwarding shadow of issued results
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs zero, pc holds last value
// RUN   | presenting vectors; accept = valid & ~stall & ~clear
// DRAIN | two cycles shifting bubbles through the shadow
// DONE  | one cycle, done=1
module exec_stim_seq
   import exec_stim_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              NUM_VEC  = 16,
   parameter logic [XLEN-1:0] RESET_PC = 64'h400,
   parameter logic [31:0]     SEED     = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall_in,
   input  logic             clear_in,
   output logic             valid,
   output logic             done,
   output logic [XLEN-1:0]  pc,
   output logic [4:0]       rd,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [XLEN-1:0]  data1,
   output logic [XLEN-1:0]  data2,
   output logic [XLEN-1:0]  imm,
   output logic             with_imm,
   output logic [ALU_W-1:0] alu_op,
   output logic             load_op,
   output logic             store_op,
`ifdef COMPRESSED_EN
   output logic             compressed,
`endif
   output logic [4:0]       ma_rd,
   output logic [4:0]       wb_rd,
   output logic [XLEN-1:0]  ma_data,
   output logic [XLEN-1:0]  wb_data
);

   localparam int          REP        = XLEN / 32;
   localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
   localparam logic [1:0]  DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

   state_t state_q, state_d;
   logic   bubble_q, bubble_d;

   logic [15:0]     vcnt_q;
   logic [1:0]      drain_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_step;

   logic [31:0] lfsr;
   logic        lfsr_load;
   logic        accept;
   logic        shift_bubble;
   logic        show;

   logic [3:0]      op_idx;
   logic [XLEN-1:0] vec_data1;
   logic [XLEN-1:0] vec_data2;
   logic [XLEN-1:0] vec_imm;
   logic [XLEN-1:0] vec_sum;

   stim_lfsr32 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (lfsr_load),
      .advance (accept),
      .state   (lfsr)
   );

   // Vector fields straight from the current LFSR value.
   assign op_idx    = lfsr[19:16];
   assign vec_data1 = {REP{lfsr}};
   assign vec_data2 = ~vec_data1;
   assign vec_imm   = {{(XLEN-12){lfsr[31]}}, lfsr[31:20]};
   assign vec_sum   = vec_data1 + (lfsr[20] ? vec_imm : vec_data2);

`ifdef COMPRESSED_EN
   assign pc_step = lfsr[21] ? XLEN'(2) : XLEN'(4);
`else
   assign pc_step = XLEN'(4);
`endif

   always_comb begin
      state_d      = state_q;
      bubble_d     = bubble_q;
      lfsr_load    = 1'b0;
      accept       = 1'b0;
      shift_bubble = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               bubble_d  = 1'b0;
               lfsr_load = 1'b1;
            end
         end
         RUN: begin
            // clear beats stall; a bubble already on the outputs retires
            // only if the stage is not stalled.
            if (clear_in) begin
               bubble_d     = 1'b1;
               shift_bubble = bubble_q & ~stall_in;
            end else if (!stall_in) begin
               if (bubble_q) begin
                  bubble_d     = 1'b0;
                  shift_bubble = 1'b1;
               end else begin
                  accept = 1'b1;
                  if (vcnt_q == LAST_IDX) begin
                     state_d = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            shift_bubble = 1'b1;
            if (drain_q == 2'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bubble_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bubble_q <= bubble_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         vcnt_q <= '0;
      end else if (lfsr_load) begin
         pc_q   <= RESET_PC;
         vcnt_q <= '0;
      end else if (accept) begin
         pc_q   <= pc_q + pc_step;
         vcnt_q <= vcnt_q + 16'd1;
      end
   end

   // Drain timer: armed outside DRAIN, counts down to terminal zero inside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_q <= '0;
      end else if (state_q != DRAIN) begin
         drain_q <= DRAIN_LOAD;
      end else if (drain_q != 2'd0) begin
         drain_q <= drain_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_rd   <= '0;
         ma_data <= '0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (accept) begin
         wb_rd   <= ma_rd;
         wb_data <= ma_data;
         ma_rd   <= lfsr[4:0];
         ma_data <= vec_sum;
      end else if (shift_bubble) begin
         wb_rd   <= ma_rd;
         wb_data <= ma_data;
         ma_rd   <= '0;
         ma_data <= '0;
      end
   end

   assign show     = (state_q == RUN) && !bubble_q;
   assign valid    = show;
   assign done     = (state_q == DONE);
   assign pc       = pc_q;
   assign rd       = show ? lfsr[4:0]   : 5'd0;
   assign rs1      = show ? lfsr[9:5]   : 5'd0;
   assign rs2      = show ? lfsr[14:10] : 5'd0;
   assign data1    = show ? vec_data1   : '0;
   assign data2    = show ? vec_data2   : '0;
   assign imm      = show ? vec_imm     : '0;
   assign with_imm = show & lfsr[20];
   assign alu_op   = show ? alu_decode(op_idx) : '0;
   assign load_op  = show && (op_idx == OPI_LOAD);
   assign store_op = show && (op_idx == OPI_STORE);
`ifdef COMPRESSED_EN
   assign compressed = show & lfsr[21];
`endif

endmodule

// File: tb/tb_exec_stim_seq.sv
// tb_exec_stim_seq: directed plus randomized bench for exec_stim_seq
// (XLEN=64, NUM_VEC=4, SEED=1) against a behavioural reference model.
// Build with COMPRESSED_EN defined to cover the compressed pc step.
module tb_exec_stim_seq;

   localparam int          XLEN     = 64;
   localparam int          NUM_VEC  = 4;
   localparam logic [63:0] RESET_PC = 64'h400;
   localparam logic [31:0] SEED     = 32'h0000_0001;
   localparam logic [31:0] MASK     = 32'h8020_0003;
`ifdef COMPRESSED_EN
   localparam bit COMP = 1'b1;
`else
   localparam bit COMP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start, stall_in, clear_in;
   logic            valid, done;
   logic [63:0]     pc, data1, data2, imm, ma_data, wb_data;
   logic [4:0]      rd, rs1, rs2, ma_rd, wb_rd;
   logic            with_imm, load_op, store_op;
   logic [8:0]      alu_op;
`ifdef COMPRESSED_EN
   logic            compressed;
`endif

   exec_stim_seq #(
      .XLEN     (XLEN),
      .NUM_VEC  (NUM_VEC),
      .RESET_PC (RESET_PC),
      .SEED     (SEED)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stall_in (stall_in),
      .clear_in (clear_in),
      .valid    (valid),
      .done     (done),
      .pc       (pc),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .data1    (data1),
      .data2    (data2),
      .imm      (imm),
      .with_imm (with_imm),
      .alu_op   (alu_op),
      .load_op  (load_op),
      .store_op (store_op),
`ifdef COMPRESSED_EN
      .compressed (compressed),
`endif
      .ma_rd    (ma_rd),
      .wb_rd    (wb_rd),
      .ma_data  (ma_data),
      .wb_data  (wb_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
   logic [31:0] vec_l [0:NUM_VEC];
   int          m_phase;
   int          m_k;
   int          m_drain;
   bit          m_bubble;
   logic [63:0] m_pc;
   logic [4:0]  m_ma_rd, m_wb_rd;
   logic [63:0] m_ma_data, m_wb_data;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return l[0] ? ((l >> 1) ^ MASK) : (l >> 1);
   endfunction

   function automatic logic [63:0] f_data1(input logic [31:0] l);
      return {l, l};
   endfunction

   function automatic logic [63:0] f_imm(input logic [31:0] l);
      logic [63:0] field;
      field = 64'(l[31:20]);
      return l[31] ? field - 64'd4096 : field;
   endfunction

   function automatic logic [63:0] f_result(input logic [31:0] l);
      logic [63:0] op2;
      op2 = l[20] ? f_imm(l) : ~f_data1(l);
      return f_data1(l) + op2;
   endfunction

   function automatic logic [8:0] f_alu(input logic [31:0] l);
      int op;
      op = int'(l[19:16]);
      if (op <= 8)  return 9'(1 << op);
      if (op >= 11) return 9'd1;
      return 9'd0;
   endfunction

   task automatic m_shift(input logic [4:0] r, input logic [63:0] d);
      m_wb_rd   = m_ma_rd;
      m_wb_data = m_ma_data;
      m_ma_rd   = r;
      m_ma_data = d;
   endtask

   task automatic model_reset();
      m_phase = 0; m_k = 0; m_drain = 0; m_bubble = 1'b0;
      m_pc = RESET_PC;
      m_ma_rd = '0; m_wb_rd = '0; m_ma_data = '0; m_wb_data = '0;
   endtask

   task automatic model_edge(input logic s, input logic st, input logic cl);
      logic [31:0] l;
      case (m_phase)
         0: if (s) begin
            m_phase = 1; m_k = 0; m_pc = RESET_PC; m_bubble = 1'b0;
         end
         1: begin
            if (cl) begin
               if (m_bubble && !st) m_shift(5'd0, 64'd0);
               m_bubble = 1'b1;
            end else if (!st) begin
               if (m_bubble) begin
                  m_shift(5'd0, 64'd0);
                  m_bubble = 1'b0;
               end else begin
                  l = vec_l[m_k];
                  m_shift(l[4:0], f_result(l));
                  m_pc = m_pc + ((COMP && l[21]) ? 64'd2 : 64'd4);
                  m_k++;
                  if (m_k == NUM_VEC) begin
                     m_phase = 2; m_drain = 2;
                  end
               end
            end
         end
         2: begin
            m_shift(5'd0, 64'd0);
            m_drain--;
            if (m_drain == 0) m_phase = 3;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      bit          sh;
      logic [31:0] l;
      sh = (m_phase == 1) && !m_bubble;
      l  = sh ? vec_l[m_k] : 32'd0;
      chk("valid",    64'(valid),    64'(sh));
      chk("done",     64'(done),     64'(m_phase == 3));
      chk("pc",       pc,            m_pc);
      chk("rd",       64'(rd),       64'(l[4:0]));
      chk("rs1",      64'(rs1),      64'(l[9:5]));
      chk("rs2",      64'(rs2),      64'(l[14:10]));
      chk("data1",    data1,         sh ? f_data1(l) : 64'd0);
      chk("data2",    data2,         sh ? ~f_data1(l) : 64'd0);
      chk("imm",      imm,           sh ? f_imm(l) : 64'd0);
      chk("with_imm", 64'(with_imm), 64'(l[20]));
      chk("alu_op",   64'(alu_op),   sh ? 64'(f_alu(l)) : 64'd0);
      chk("load_op",  64'(load_op),  64'(sh && l[19:16] == 4'd9));
      chk("store_op", 64'(store_op), 64'(sh && l[19:16] == 4'd10));
      chk("ma_rd",    64'(ma_rd),    64'(m_ma_rd));
      chk("ma_data",  ma_data,       m_ma_data);
      chk("wb_rd",    64'(wb_rd),    64'(m_wb_rd));
      chk("wb_data",  wb_data,       m_wb_data);
`ifdef COMPRESSED_EN
      chk("compressed", 64'(compressed), 64'(l[21]));
`endif
   endtask

   // Inputs are driven 1ns after an edge, the model steps with the next edge
   // and the DUT is sampled 1ns after it.
   task automatic cycle(input logic s, input logic st, input logic cl);
      start = s; stall_in = st; clear_in = cl;
      @(posedge clk);
      model_edge(s, st, cl);
      #1;
      compare_all();
   endtask

   task automatic run_to_done(input int stall_pct, input int clear_pct,
                              output int accepts, output int dones);
      logic s, st, cl;
      bit   seen;
      accepts = 0; dones = 0; seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         s  = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 99) < stall_pct);
         cl = ($urandom_range(0, 99) < clear_pct);
         if (valid && !st && !cl) accepts++;
         cycle(s, st, cl);
         if (done) begin
            dones++;
            seen = 1'b1;
         end
      end
      chk("run_done_seen", 64'(dones), 64'd1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("done_one_cycle", 64'(done), 64'd0);
   endtask

   int acc, dn;
   logic [63:0] snap_pc;
   logic [4:0]  snap_rd;

   initial begin
      vec_l[0] = SEED;
      for (int i = 1; i <= NUM_VEC; i++) vec_l[i] = lfsr_step(vec_l[i-1]);

      rst_n = 1'b0; start = 1'b0; stall_in = 1'b0; clear_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      compare_all();
      chk("reset_pc", pc, 64'h400);
      chk("reset_valid", 64'(valid), 64'd0);
      rst_n = 1'b1;

      // First vector and its shadow.
      cycle(1'b1, 1'b0, 1'b0);
      chk("v0_pc",    pc,          64'h400);
      chk("v0_rd",    64'(rd),     64'd1);
      chk("v0_rs1",   64'(rs1),    64'd0);
      chk("v0_rs2",   64'(rs2),    64'd0);
      chk("v0_alu",   64'(alu_op), 64'd1);
      chk("v0_wimm",  64'(with_imm), 64'd0);
      chk("v0_data1", data1,       64'h0000_0001_0000_0001);
      chk("v0_data2", data2,       64'hFFFF_FFFE_FFFF_FFFE);
      chk("v0_valid", 64'(valid),  64'd1);
      cycle(1'b0, 1'b0, 1'b0);
      chk("v0_ma_rd",   64'(ma_rd), 64'd1);
      chk("v0_ma_data", ma_data,    64'hFFFF_FFFF_FFFF_FFFF);
      chk("v1_pc",      pc,         64'h404);

      // Clean run to completion.
      run_to_done(0, 0, acc, dn);
      chk("clean_accepts", 64'(1 + acc), 64'(NUM_VEC));
      chk("drain_wb_rd",   64'(wb_rd),   64'd0);

      // Stall mid-run for three cycles.
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      snap_pc = m_pc;
      snap_rd = vec_l[m_k][4:0];
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         chk("stall_pc", pc, snap_pc);
         chk("stall_rd", 64'(rd), 64'(snap_rd));
      end
      run_to_done(0, 0, acc, dn);
      chk("stall_accepts", 64'(1 + acc), 64'(NUM_VEC));

      // clear together with stall: bubble, then the same vector again.
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      snap_pc = m_pc;
      snap_rd = vec_l[m_k][4:0];
      cycle(1'b0, 1'b1, 1'b1);
      chk("bubble_valid", 64'(valid), 64'd0);
      chk("bubble_rd",    64'(rd),    64'd0);
      cycle(1'b0, 1'b0, 1'b0);
      chk("repres_valid", 64'(valid), 64'd1);
      chk("repres_pc",    pc,         snap_pc);
      chk("repres_rd",    64'(rd),    64'(snap_rd));
      chk("repres_ma_rd", 64'(ma_rd), 64'd0);
      run_to_done(0, 0, acc, dn);
      chk("clear_accepts", 64'(1 + acc), 64'(NUM_VEC));

      // Reset mid-run: immediate reset values, no done afterwards.
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_mid_pc",    pc,            64'h400);
      chk("rst_mid_valid", 64'(valid),    64'd0);
      chk("rst_mid_ma",    64'(ma_rd),    64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      compare_all();
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (done) dn++;
      end
      chk("no_done_after_rst", 64'(dn), 64'd0);

      // Randomized runs with stalls, clears and stray start pulses.
      for (int r = 0; r < 8; r++) begin
         cycle(1'b1, 1'b0, 1'b0);
         run_to_done(25, 12, acc, dn);
         chk("rand_accepts", 64'(acc), 64'(NUM_VEC));
         for (int j = 0; j < int'($urandom_range(0, 3)); j++)
            cycle(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
